// File: rtl/scroll_layer_ctrl.sv
// Tick-paced vertical scroll controller for one terrain layer.
// Optional pause input: define SCROLL_LAYER_PAUSE_EN.
module scroll_layer_ctrl #(
  parameter int NUM_BLOCKS  = 7,
  parameter int Y_BASE      = 25,
  parameter int SCROLL_DIST = 150,
  parameter int STEP_PX     = 1,
  parameter int TICK_DIV    = 1,
  parameter int DIR_DOWN    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  module_en,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  load,
`ifdef SCROLL_LAYER_PAUSE_EN
  input  logic                  pause,
`endif
  input  logic [NUM_BLOCKS-1:0] layer_map_in,
  input  logic [NUM_BLOCKS-1:0] block_type_in,
  output logic [NUM_BLOCKS-1:0] layer_map_out,
  output logic [NUM_BLOCKS-1:0] block_type_out,
  output logic [7:0]            shift_y,
  output logic [11:0]           ypos,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCROLL = 2'd1,
    S_END    = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] divider;
  logic       pending;
  logic       tick_eff;
  logic       step_go;
  logic       at_end;
  logic       go;
  logic [8:0] sum;

`ifdef SCROLL_LAYER_PAUSE_EN
  assign tick_eff = tick & ~pause;
`else
  assign tick_eff = tick;
`endif

  // 9-bit sum so a large final step never wraps before the clamp
  assign sum     = {1'b0, shift_y} + 9'(STEP_PX);
  assign step_go = (state == S_SCROLL) && tick_eff
                && (divider >= 8'(TICK_DIV - 1));
  assign at_end  = step_go && (sum >= 9'(SCROLL_DIST));
  // load+start together defers the scroll through pending
  assign go      = pending || (start && !load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (module_en) begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (go) state_nx = S_SCROLL;
      S_SCROLL: if (at_end) state_nx = S_END;
      S_END:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_map_out  <= '0;
      block_type_out <= '0;
      shift_y        <= '0;
      divider        <= '0;
      pending        <= 1'b0;
    end else if (module_en) begin
      case (state)
        S_IDLE: begin
          if (load) begin
            layer_map_out  <= layer_map_in;
            block_type_out <= block_type_in;
          end
          if (go) begin
            shift_y <= '0;
            divider <= '0;
            pending <= 1'b0;
          end else if (start) begin
            pending <= 1'b1;
          end
        end
        S_SCROLL: begin
          if (start) pending <= 1'b1;
          if (step_go) begin
            divider <= '0;
            shift_y <= at_end ? 8'(SCROLL_DIST) : sum[7:0];
          end else if (tick_eff) begin
            divider <= divider + 8'd1;
          end
        end
        S_END: begin
          if (start) pending <= 1'b1;
          shift_y        <= '0;
          layer_map_out  <= layer_map_in;
          block_type_out <= block_type_in;
        end
        default: begin
          shift_y <= '0;
          divider <= '0;
        end
      endcase
    end
  end

  assign ypos = (DIR_DOWN != 0)
              ? 12'(Y_BASE) + {4'd0, shift_y}
              : 12'(Y_BASE) - {4'd0, shift_y};

endmodule
